// File: rtl/led_trail_pwm.sv
// PWM fade-trail for an LED chaser: each lit channel fades out linearly, or
// quadratically when LED_TRAIL_GAMMA_EN is defined.
`timescale 1ns/1ps

module led_trail_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                CLK_i,
  input  logic                RSTn_i,
  input  logic                led_i,
  input  logic                tick_i,
  input  logic [PWM_BITS-1:0] pwm_i,
  output logic                led_o
);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty;
  logic                led_q, led_d;

  // A lit input outranks a coincident decay tick.
  always_comb begin
    level_d = level_q;
    if (led_i)
      level_d = LEVEL_MAX;
    else if (tick_i && (level_q != '0))
      level_d = level_q - LVL_ONE;
  end

`ifdef LED_TRAIL_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq   = level_q * level_q;
  assign duty = PWM_BITS'(sq >> PWM_BITS);
`else
  assign duty = level_q;
`endif

  // Full level bypasses the comparator so a held input never flickers.
  assign led_d = (level_q == LEVEL_MAX) || (pwm_i < duty);

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q & RSTn_i;
endmodule

module led_trail_pwm #(
  parameter int          LED_NUM      = 8,
  parameter int          PWM_BITS     = 8,
  parameter int unsigned DECAY_CYCLES = 32'd250_000
) (
  input  logic               CLK_i,
  input  logic               RSTn_i,
  input  logic [LED_NUM-1:0] LED_i,
  output logic [LED_NUM-1:0] LED_o
);
  localparam logic [31:0]         DECAY_LAST = 32'(DECAY_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [31:0]         decay_cnt_q, decay_cnt_d;
  logic                decay_tick;

  assign decay_tick  = (decay_cnt_q == DECAY_LAST);
  assign decay_cnt_d = decay_tick ? 32'd0 : decay_cnt_q + 32'd1;
  assign pwm_cnt_d   = pwm_cnt_q + PWM_ONE;

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      pwm_cnt_q   <= '0;
      decay_cnt_q <= '0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      decay_cnt_q <= decay_cnt_d;
    end
  end

  for (genvar k = 0; k < LED_NUM; k++) begin : g_lane
    led_trail_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .CLK_i  (CLK_i),
      .RSTn_i (RSTn_i),
      .led_i  (LED_i[k]),
      .tick_i (decay_tick),
      .pwm_i  (pwm_cnt_q),
      .led_o  (LED_o[k])
    );
  end
endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm: LED_NUM=8, PWM_BITS=4, DECAY_CYCLES=4,
// plus a DECAY_CYCLES=1000 instance for the duty-ratio check.
`timescale 1ns/1ps

module tb_led_trail_pwm;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n, rst_s_n;
  logic [7:0] led_in, led_s, led_o, led_so;

  always #5 clk = ~clk;

  led_trail_pwm #(.LED_NUM(8), .PWM_BITS(4), .DECAY_CYCLES(D)) dut (
    .CLK_i(clk), .RSTn_i(rst_n), .LED_i(led_in), .LED_o(led_o));

  led_trail_pwm #(.LED_NUM(8), .PWM_BITS(4), .DECAY_CYCLES(1000)) dut_s (
    .CLK_i(clk), .RSTn_i(rst_s_n), .LED_i(led_s), .LED_o(led_so));

  int n_vec = 0, n_bad = 0;
  int m_lvl [8];
  int m_pwm, m_dcnt;
  logic [7:0] m_out;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int duty(input int l);
`ifdef LED_TRAIL_GAMMA_EN
    return (l * l) >> 4;
`else
    return l;
`endif
  endfunction

  task automatic mreset();
    for (int k = 0; k < 8; k++) m_lvl[k] = 0;
    m_pwm = 0; m_dcnt = 0; m_out = 8'h00;
  endtask

  // Advance the reference model and the clock by one edge, then compare.
  task automatic step(input bit do_chk, input string tag);
    logic [7:0] o;
    bit t;
    for (int k = 0; k < 8; k++) o[k] = (m_lvl[k] == 15) || (m_pwm < duty(m_lvl[k]));
    t = (m_dcnt == D - 1);
    for (int k = 0; k < 8; k++)
      if (led_in[k]) m_lvl[k] = 15;
      else if (t && m_lvl[k] > 0) m_lvl[k] = m_lvl[k] - 1;
    m_pwm  = (m_pwm + 1) % 16;
    m_dcnt = t ? 0 : m_dcnt + 1;
    m_out  = o;
    @(posedge clk); #1;
    if (do_chk) chk(tag, led_o, m_out);
  endtask

  initial begin
    int cnt;
    int i;
    rst_n = 1'b0; rst_s_n = 1'b0; led_in = 8'hFF; led_s = 8'h00;
    mreset();

    // Reset with all inputs high keeps outputs dark.
    #2 chk("rst_hold_t0", led_o, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("rst_hold_edges", led_o, 8'h00);
    chk("rst_hold_slow", led_so, 8'h00);
    #3 rst_n = 1'b1;
    step(1, "rel_e1");
    chk("rel_e1_dark", led_o, 8'h00);
    step(1, "rel_e2");
    chk("rel_e2_lit", led_o, 8'hFF);

    // Fresh reset, inputs low: level 0 means constantly dark.
    rst_n = 1'b0; led_in = 8'h00; mreset();
    #1 chk("rst2_clear", led_o, 8'h00);
    #1 rst_n = 1'b1;
    repeat (5) step(1, "dark");
    chk("dark_idle", led_o, 8'h00);

    // Single-cycle latency and steady-on while held.
    led_in = 8'h01;
    step(1, "rise_n");
    chk("rise_n_dark", led_o, 8'h00);
    repeat (100) begin
      step(1, "hold");
      chk("hold_ch0", led_o, 8'h01);
    end

    // Linear/gamma fade of channel 0 to zero, then permanently dark.
    led_in = 8'h00;
    repeat (80) step(1, "fade0");
    repeat (30) begin
      step(1, "fade0_done");
      chk("fade0_dark", led_o, 8'h00);
    end

    // Re-rise coinciding with a decay tick while level is 9: load wins.
    led_in = 8'h08;
    repeat (3) step(1, "ch3_full");
    led_in = 8'h00;
    i = 0;
    while (i < 100 && !(m_lvl[3] == 9 && m_dcnt == D - 1)) begin
      step(1, "fade3");
      i++;
    end
    chk("ch3_reach9", 8'(i < 100), 8'h01);
    led_in = 8'h08;
    step(1, "coincide");
    led_in = 8'h00;
    step(1, "load_wins");
    chk("load_wins_ch3", {7'b0, led_o[3]}, 8'h01);
    repeat (70) step(1, "refade3");

    // Async reset pulse mid-fade on channels 0-2.
    led_in = 8'h07;
    repeat (3) step(1, "ch012_full");
    led_in = 8'h00;
    step(1, "ch012_drop");
    i = 0;
    while (i < 40 && m_out != 8'h07) begin
      step(1, "ch012_fade");
      i++;
    end
    chk("pre_pulse_lit", led_o, 8'h07);
    #2 rst_n = 1'b0;
    #0.5 chk("async_clr", led_o, 8'h00);
    #0.5 rst_n = 1'b1;
    mreset();
    repeat (40) begin
      step(1, "post_rst");
      chk("post_rst_dark", led_o, 8'h00);
    end
    led_in = 8'h20;
    step(1, "ch5_rise");
    step(1, "ch5_lit");
    chk("ch5_lit_hand", led_o, 8'h20);

    // Slow instance: level parked at 8 gives the duty ratio.
    #2 rst_s_n = 1'b1; led_s = 8'h01;
    repeat (2) step(0, "");
    chk("slow_lit", led_so, 8'h01);
    repeat (8) step(0, "");
    led_s = 8'h00;
    repeat (7490) step(0, "");
    cnt = 0;
    repeat (16) begin
      step(0, "");
      cnt += int'(led_so[0]);
      chk("slow_others_dark", {led_so[7:1], 1'b0}, 8'h00);
    end
`ifdef LED_TRAIL_GAMMA_EN
    chk("duty_lvl8", 8'(cnt), 8'd4);
`else
    chk("duty_lvl8", 8'(cnt), 8'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
